// File: rtl/whack_pkg.sv
// Shared constants, state encoding and helpers for the whack-a-mole scheduler.
package whack_pkg;

    localparam int unsigned N_MOLES = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned SCORE_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_UP   = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    function automatic logic [N_MOLES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return N_MOLES'(1) << idx;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV clocks; clear restarts the count from 0.
module tick_gen #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: picks moles from the lfsr index, times gap/up windows, scores hits.
// Optional macro SPEEDUP_EN shortens the up window as the score grows.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned GAP_TICKS    = 500,
    parameter int unsigned UP_TICKS     = 1000,
    parameter int unsigned UP_MIN_TICKS = 250,
    parameter int unsigned MAX_MISSES   = 5
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 start,
    // "rand" is a SystemVerilog keyword, so the lfsr index arrives as rand_in
    input  logic [IDX_W-1:0]     rand_in,
    input  logic [N_MOLES-1:0]   btn,
    output logic [N_MOLES-1:0]   mole_onehot,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 active,
    output logic                 game_over
);

    if (CLK_DIV < 2 || GAP_TICKS < 1 || UP_TICKS < 1 || UP_MIN_TICKS < 1 ||
        MAX_MISSES < 1 || MAX_MISSES > 255) begin : g_param_check
        $error("mole_scheduler: illegal parameter set");
    end

    logic [1:0]          state_q, state_d;
    logic [31:0]         timer_q, timer_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_MOLES-1:0]  mole_q, mole_d;
    logic [N_MOLES-1:0]  btn_q;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SCORE_W-1:0]  misses_q, misses_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;
    logic [IDX_W-1:0]    cand;
    logic                tick;
    logic                clear;
    logic [31:0]         up_ticks;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (CLK100MHZ),
        .rst   (reset),
        .clear (clear),
        .tick  (tick)
    );

`ifdef SPEEDUP_EN
    logic [31:0] up_ticks_q, up_ticks_d;
    logic [31:0] speed_dec;

    assign up_ticks  = up_ticks_q;
    assign speed_dec = 32'(score_q >> 2);

    always_comb begin
        up_ticks_d = up_ticks_q;
        if (state_q == S_WAIT && state_d == S_UP) begin
            up_ticks_d = (UP_TICKS > UP_MIN_TICKS + speed_dec) ? UP_TICKS - speed_dec
                                                               : UP_MIN_TICKS;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            up_ticks_q <= UP_TICKS;
        end else begin
            up_ticks_q <= up_ticks_d;
        end
    end
`else
    assign up_ticks = UP_TICKS;
`endif

    assign cand = rand_in;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        mole_d   = mole_q;
        score_d  = score_q;
        misses_d = misses_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        clear    = 1'b0;

        case (state_q)
            S_IDLE: begin
                mole_d = '0;
                if (start) begin
                    state_d  = S_WAIT;
                    score_d  = '0;
                    misses_d = '0;
                    timer_d  = '0;
                    clear    = 1'b1;
                end
            end
            S_WAIT: begin
                if (tick) begin
                    timer_d = timer_q + 32'd1;
                end
                if (!start) begin
                    state_d = S_IDLE;
                    mole_d  = '0;
                end else if (tick && timer_q == GAP_TICKS - 1) begin
                    // idx_q doubles as last_idx: never light the same mole twice in a row
                    idx_d   = (cand == idx_q) ? cand + IDX_W'(1) : cand;
                    mole_d  = idx_onehot(idx_d);
                    state_d = S_UP;
                    timer_d = '0;
                    clear   = 1'b1;
                end
            end
            S_UP: begin
                if (tick) begin
                    timer_d = timer_q + 32'd1;
                end
                if (!start) begin
                    state_d = S_IDLE;
                    mole_d  = '0;
                end else if (btn_q[idx_q]) begin
                    score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                    hit_d   = 1'b1;
                    mole_d  = '0;
                    state_d = S_WAIT;
                    timer_d = '0;
                    clear   = 1'b1;
                end else if (tick && timer_q == up_ticks - 1) begin
                    misses_d = misses_q + SCORE_W'(1);
                    miss_d   = 1'b1;
                    mole_d   = '0;
                    if (misses_d == SCORE_W'(MAX_MISSES)) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_WAIT;
                        timer_d = '0;
                        clear   = 1'b1;
                    end
                end
            end
            S_OVER: begin
                mole_d = '0;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                mole_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            mole_q   <= '0;
            btn_q    <= '0;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            mole_q   <= mole_d;
            btn_q    <= btn;
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign mole_onehot = mole_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign active      = (state_q == S_WAIT) || (state_q == S_UP);
    assign game_over   = (state_q == S_OVER);

endmodule
